multicast_sender: RTL and testbench

Transmit end of the PE-array multicast bus. Accepts (tag, value) beats from the global-buffer side, queues them in a small FIFO, and drives `tag_out`/`enable_out`/`value_out` onto the bus shared by the multicast controllers, holding each beat until the bus `ready_in` is sampled high. A controller whose programmed ID equals `tag_out` captures the value.

---
 rtl/multicast_sender_if.sv | 28 ++
 rtl/multicast_sender.sv | 96 +++++++++
 tb/tb_multicast_sender.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/multicast_sender_if.sv
// Multicast bus handshake bundle.
// Upstream side: in_valid/in_tag/in_value in, in_ready back.
// Bus side: tag_out/enable_out/value_out out, ready_in back.
// slave  : view taken by the sender (multicast_sender).
// master : view taken by whoever feeds the sender and models the bus.
interface multicast_sender_if #(
  parameter int ID_LEN    = 4,
  parameter int VALUE_LEN = 32
);
  logic                 in_valid;
  logic [ID_LEN-1:0]    in_tag;
  logic [VALUE_LEN-1:0] in_value;
  logic                 in_ready;
  logic [ID_LEN-1:0]    tag_out;
  logic                 enable_out;
  logic [VALUE_LEN-1:0] value_out;
  logic                 ready_in;

  modport slave (
    input  in_valid, in_tag, in_value, ready_in,
    output in_ready, tag_out, enable_out, value_out
  );

  modport master (
    output in_valid, in_tag, in_value, ready_in,
    input  in_ready, tag_out, enable_out, value_out
  );
endinterface

// File: rtl/multicast_sender.sv
// Transmit end of the PE-array multicast bus.
// Upstream (tag, value) beats are queued in a DEPTH-entry FIFO and handed to
// an output register (OR) that drives the bus; a beat is held until ready_in
// is sampled high. An empty sender bypasses the FIFO so a beat accepted at
// edge N is on the bus in cycle N+1.
// Ports:
//   clk, rst   : clock, async active-low reset
//   flush      : synchronous clear of all queued and in-flight beats
//   bus        : handshake bundle (slave view)
//   count      : beats held (FIFO + OR), 0..DEPTH+1
//   idle       : count == 0
module multicast_sender #(
  parameter int ID_LEN    = 4,
  parameter int VALUE_LEN = 32,
  parameter int DEPTH     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  multicast_sender_if.slave            bus,
  output logic [$clog2(DEPTH+2)-1:0]   count,
  output logic                         idle
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+2);

  typedef struct packed {
    logic [ID_LEN-1:0]    tag;
    logic [VALUE_LEN-1:0] value;
  } beat_t;

  beat_t         mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  beat_t         or_q;
  logic          or_vld;

  beat_t         in_beat;
  logic          fifo_empty, fifo_full;
  logic          acc, xfer, or_load, pop, bypass, push;
  logic [AW:0]   fifo_cnt;

  assign in_beat    = '{tag: bus.in_tag, value: bus.in_value};
  // Extra wrap bit distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign bus.in_ready = !fifo_full && !flush;
  assign acc     = bus.in_valid && bus.in_ready;
  assign xfer    = or_vld && bus.ready_in;
  assign or_load = !or_vld || xfer;
  assign pop     = or_load && !fifo_empty && !flush;
  // Bypass only when nothing is queued ahead, so ordering stays strict FIFO.
  assign bypass  = or_load && fifo_empty && acc;
  assign push    = acc && !bypass;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      or_vld <= 1'b0;
      or_q   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      or_vld <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (or_load) begin
        if (!fifo_empty) begin
          or_q   <= mem[rd_ptr[AW-1:0]];
          or_vld <= 1'b1;
        end else if (acc) begin
          or_q   <= in_beat;
          or_vld <= 1'b1;
        end else begin
          or_vld <= 1'b0;
        end
      end
    end
  end

  // Storage needs no reset: entries are only read behind a valid pointer.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_beat;
  end

  assign bus.enable_out = or_vld;
  assign bus.tag_out    = or_vld ? or_q.tag   : '0;
  assign bus.value_out  = or_vld ? or_q.value : '0;

  assign fifo_cnt = wr_ptr - rd_ptr;
  assign count    = CW'(fifo_cnt) + CW'(or_vld);
  assign idle     = (count == '0);
endmodule

// File: tb/tb_multicast_sender.sv
module tb_multicast_sender;
  localparam int IDL = 4;
  localparam int VL  = 32;
  localparam int DP  = 4;
  localparam int CW  = $clog2(DP+2);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic [CW-1:0] count;
  logic          idle;

  multicast_sender_if #(.ID_LEN(IDL), .VALUE_LEN(VL)) bus_if ();

  multicast_sender #(.ID_LEN(IDL), .VALUE_LEN(VL), .DEPTH(DP)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus_if),
    .count (count),
    .idle  (idle)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: beats pushed when accepted, popped when they transfer.
  logic [IDL+VL-1:0] exp_q[$];
  logic              have_prev = 1'b0;
  logic [IDL+VL:0]   prev_bus;

  always @(negedge clk) begin
    if (!rst || flush) begin
      exp_q.delete();
      have_prev = 1'b0;
    end else begin
      if (have_prev)
        check("bus_hold", {bus_if.enable_out, bus_if.tag_out, bus_if.value_out}, prev_bus);
      if (bus_if.enable_out && bus_if.ready_in) begin
        if (exp_q.size() == 0)
          check("unexpected_beat", {bus_if.tag_out, bus_if.value_out}, 64'hx);
        else
          check("sb_beat", {bus_if.tag_out, bus_if.value_out}, exp_q.pop_front());
      end
      if (bus_if.in_valid && bus_if.in_ready)
        exp_q.push_back({bus_if.in_tag, bus_if.in_value});
      have_prev = bus_if.enable_out && !bus_if.ready_in;
      prev_bus  = {bus_if.enable_out, bus_if.tag_out, bus_if.value_out};
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [IDL-1:0] t, input logic [VL-1:0] d, input logic r);
    bus_if.in_valid = v;
    bus_if.in_tag   = t;
    bus_if.in_value = d;
    bus_if.ready_in = r;
  endtask

  typedef struct {
    logic           vld;
    logic [IDL-1:0] tag;
    logic [VL-1:0]  val;
    logic           rdy;
    int             cnt;
    logic           ird;
    logic           en;
    logic [IDL-1:0] etag;
    logic [VL-1:0]  eval;
  } vec_t;

  function automatic vec_t mk(input logic v, input int t, input logic r,
                              input int c, input logic ir, input logic e, input int et);
    vec_t x;
    x.vld = v; x.tag = IDL'(t); x.val = VL'(100 + t); x.rdy = r;
    x.cnt = c; x.ird = ir; x.en = e; x.etag = IDL'(et);
    x.eval = e ? VL'(100 + et) : '0;
    return x;
  endfunction

  vec_t tbl[12];

  initial begin
    int acc_n;
    int cyc;

    // stalled fill then drain: inputs applied, outputs seen in that same cycle
    tbl[0]  = mk(1, 0, 0, 0, 1, 0, 0);
    tbl[1]  = mk(1, 1, 0, 1, 1, 1, 0);
    tbl[2]  = mk(1, 2, 0, 2, 1, 1, 0);
    tbl[3]  = mk(1, 3, 0, 3, 1, 1, 0);
    tbl[4]  = mk(1, 4, 0, 4, 1, 1, 0);
    tbl[5]  = mk(0, 0, 0, 5, 0, 1, 0);
    tbl[6]  = mk(0, 0, 1, 5, 0, 1, 0);
    tbl[7]  = mk(0, 0, 1, 4, 1, 1, 1);
    tbl[8]  = mk(0, 0, 1, 3, 1, 1, 2);
    tbl[9]  = mk(0, 0, 1, 2, 1, 1, 3);
    tbl[10] = mk(0, 0, 1, 1, 1, 1, 4);
    tbl[11] = mk(0, 0, 1, 0, 1, 0, 0);

    drive(0, 0, 0, 0);
    #3;
    check("rst_en",    bus_if.enable_out, 0);
    check("rst_tag",   bus_if.tag_out, 0);
    check("rst_val",   bus_if.value_out, 0);
    check("rst_count", count, 0);
    check("rst_idle",  idle, 1);
    check("rst_ready", bus_if.in_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    next_cycle();

    // single beat, bypass latency
    drive(1, 3, 32'hDEADBEEF, 1);
    @(negedge clk);
    check("t1_en_before", bus_if.enable_out, 0);
    next_cycle();
    drive(0, 0, 0, 1);
    @(negedge clk);
    check("t1_en",  bus_if.enable_out, 1);
    check("t1_tag", bus_if.tag_out, 3);
    check("t1_val", bus_if.value_out, 32'hDEADBEEF);
    next_cycle();
    @(negedge clk);
    check("t1_en_after", bus_if.enable_out, 0);
    check("t1_idle", idle, 1);
    next_cycle();

    // table: fill to full with bus stalled, then drain
    foreach (tbl[i]) begin
      drive(tbl[i].vld, tbl[i].tag, tbl[i].val, tbl[i].rdy);
      @(negedge clk);
      check($sformatf("tbl%0d_count", i), count, tbl[i].cnt);
      check($sformatf("tbl%0d_ready", i), bus_if.in_ready, tbl[i].ird);
      check($sformatf("tbl%0d_en", i), bus_if.enable_out, tbl[i].en);
      check($sformatf("tbl%0d_tag", i), bus_if.tag_out, tbl[i].etag);
      check($sformatf("tbl%0d_val", i), bus_if.value_out, tbl[i].eval);
      next_cycle();
    end

    // back-to-back streaming through the bypass path
    for (int i = 0; i < 20; i++) begin
      drive(1, IDL'(i), VL'(i + 1), 1);
      @(negedge clk);
      check("t3_count_le1", count <= 1, 1);
      if (i > 0) check("t3_no_bubble", bus_if.enable_out, 1);
      next_cycle();
    end
    drive(0, 0, 0, 1);
    @(negedge clk);
    check("t3_last_en", bus_if.enable_out, 1);
    check("t3_last_val", bus_if.value_out, 20);
    next_cycle();
    @(negedge clk);
    check("t3_done", bus_if.enable_out, 0);
    next_cycle();

    // random traffic, many pointer wraps
    acc_n = 0;
    cyc = 0;
    while (acc_n < 1000 && cyc < 20000) begin
      drive(1'($urandom_range(0, 1)), IDL'($urandom), VL'($urandom), 1'($urandom_range(0, 1)));
      @(negedge clk);
      if (bus_if.in_valid && bus_if.in_ready) acc_n++;
      if (cyc % 50 == 0) check("rnd_idle", idle, count == 0);
      next_cycle();
      cyc++;
    end
    check("rnd_accepted", acc_n, 1000);
    drive(0, 0, 0, 1);
    cyc = 0;
    while (!idle && cyc < 20) begin
      next_cycle();
      cyc++;
    end
    @(negedge clk);
    check("rnd_drained", idle, 1);
    check("rnd_sb_empty", exp_q.size(), 0);
    next_cycle();

    // flush with a queue and a competing input
    for (int i = 1; i <= 3; i++) begin
      drive(1, IDL'(i), VL'(i * 11), 0);
      next_cycle();
    end
    drive(1, 5, 55, 0);
    flush = 1'b1;
    @(negedge clk);
    check("fl_ready_low", bus_if.in_ready, 0);
    next_cycle();
    flush = 1'b0;
    drive(0, 0, 0, 0);
    @(negedge clk);
    check("fl_en",    bus_if.enable_out, 0);
    check("fl_count", count, 0);
    check("fl_tag",   bus_if.tag_out, 0);
    next_cycle();
    drive(1, 7, 77, 1);
    next_cycle();
    drive(0, 0, 0, 1);
    @(negedge clk);
    check("fl_after_en",  bus_if.enable_out, 1);
    check("fl_after_tag", bus_if.tag_out, 7);
    check("fl_after_val", bus_if.value_out, 77);
    next_cycle();

    // async reset while a beat is on the bus
    drive(1, 9, 99, 0);
    next_cycle();
    drive(1, 10, 1010, 0);
    next_cycle();
    drive(0, 0, 0, 0);
    @(negedge clk);
    check("rs_en_pre", bus_if.enable_out, 1);
    #2;
    rst = 1'b0;
    #1;
    check("rs_en",    bus_if.enable_out, 0);
    check("rs_tag",   bus_if.tag_out, 0);
    check("rs_val",   bus_if.value_out, 0);
    check("rs_count", count, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b1;
    next_cycle();
    @(negedge clk);
    check("rs_rel_count", count, 0);
    check("rs_rel_idle",  idle, 1);
    check("rs_rel_ready", bus_if.in_ready, 1);
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
